entry_exit_detector: RTL
========================

Name: entry_exit_detector

Overview:
- Upstream stage of the parking-lot occupancy counter (4-bit up/down counter with up, down, enable inputs).
- Watches two beam sensors: A is outside, B is inside.
- Synchronizes and debounces both sensors, then runs a sequence FSM that recognises complete vehicle entries (A→AB→B→clear) and exits (B→BA→A→clear).
- For each complete transit, emits a one-cycle command on up/down/enable that drives the counter directly.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive cycles a synchronized sensor must hold a new value before the debounced value changes (legal range 1..255).
- CNT_W, 8, width of each per-sensor debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
- sensor_a  input  1  outer beam, asynchronous; 1 = blocked.
- sensor_b  input  1  inner beam, asynchronous; 1 = blocked.
- up  output  1  high with enable for one cycle on a completed entry.
- down  output  1  high with enable for one cycle on a completed exit.
- enable  output  1  one-cycle count strobe; high only when exactly one of up/down is high.
- deb_ab  output  2  debounced {a,b}, for observation.

Behaviour:
- Reset (synchronous, active-high):
  - Sync flops, debounced values and debounce counters go to 0.
  - FSM goes to IDLE.
  - up, down, enable are 0 and deb_ab is 2'b00 in the cycle after reset is sampled.
  - Reset mid-transit discards the partial sequence; no pulse is emitted.
- Synchronizer: two flops per sensor. A pin change sampled at edge k appears on sync_x after edge k+1.
- Debounce, per sensor, independent:
  - If sync_x == deb_x, the counter clears to 0.
  - Otherwise the counter increments.
  - At the edge where the counter would reach DEBOUNCE_CYCLES, deb_x takes sync_x and the counter clears.
  - Pulses shorter than DEBOUNCE_CYCLES cycles are ignored.
  - deb_x changes at edge k+1+DEBOUNCE_CYCLES.
- FSM: 8 states, updated from deb_ab = {deb_a, deb_b}.
  - IDLE: 10→EN1; 01→EX1; 11→WAIT_CLR; 00 stays.
  - EN1: 11→EN2; 00→IDLE (car backed out); 01→WAIT_CLR.
  - EN2: 01→EN3; 10→EN1; 00→WAIT_CLR.
  - EN3: 00→IDLE and emit entry; 11→EN2; 10→WAIT_CLR.
  - EX1: 11→EX2; 00→IDLE; 10→WAIT_CLR.
  - EX2: 10→EX3; 01→EX1; 00→WAIT_CLR.
  - EX3: 00→IDLE and emit exit; 11→EX2; 01→WAIT_CLR.
  - WAIT_CLR: 00→IDLE; any other value stays.
  - Any unlisted value holds the current state.
- Outputs are registered and set on the same edge as the emitting transition:
  - entry → up=1, down=0, enable=1 for exactly one cycle;
  - exit → up=0, down=1, enable=1 for exactly one cycle;
  - otherwise all three are 0.
- Latency: the final sensor clearing, sampled at edge k, gives enable high in the cycle after edge k+2+DEBOUNCE_CYCLES.
- Back-to-back transits: a new transit is accepted from the cycle IDLE is re-entered, so minimum pulse spacing equals the sequence duration. There are no overlapping transits.
- Simultaneous A and B edges are treated as one double-bit change and go to WAIT_CLR where listed.
- No saturation or occupancy limit is applied here; limits belong to the counter.

Optional Feature:
- Macro SEQ_ERR_EN.
- Defined:
  - Adds output port seq_err (1 bit, reset 0).
  - seq_err is high for exactly one cycle on every transition into WAIT_CLR, including from IDLE on 11.
  - It is not asserted while remaining in WAIT_CLR.
- Undefined: the port is absent and WAIT_CLR behaviour is unchanged.

Test Plan (DEBOUNCE_CYCLES=4):
- Full entry: a=1 for 10 cycles, a=b=1 for 10, b=1 only for 10, both 0 → exactly one cycle up=1, enable=1, down=0, 6 cycles after the final clear is sampled; the 4-bit counter goes 0→1.
- Full exit, same timing with a/b swapped → one cycle down=1, enable=1; counter 1→0. An exit from 0 is still pulsed; wrap handling is the counter's job.
- Glitch rejection: 3-cycle pulse on sensor_a with b=0 → deb_ab stays 00, FSM stays IDLE, enable never 1. A 4-cycle pulse changes deb_a.
- Aborted entry: 10 → 11 → 10 → 00 → FSM returns to IDLE, no pulse. Then a legal entry → one up pulse.
- Illegal jump: 10 then directly 01 → WAIT_CLR, no pulse (seq_err one cycle if SEQ_ERR_EN); stays until 00, then a legal exit is counted normally.
- Reset mid-transit: assert reset for 1 cycle while in EN2 → all outputs 0 next cycle and FSM IDLE. Releasing b, then a, gives no pulse.

Source files
------------

// File: rtl/entry_exit_detector.sv
// Two-beam vehicle entry/exit detector: synchronize, debounce, then sequence-match A/B.
// Optional macro SEQ_ERR_EN adds a one-cycle seq_err strobe on every entry into WAIT_CLR.
module entry_exit_detector #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sensor_a,
   input  logic       sensor_b,
   output logic       up,
   output logic       down,
   output logic       enable,
`ifdef SEQ_ERR_EN
   output logic       seq_err,
`endif
   output logic [1:0] deb_ab
);

   localparam int NUM_SENS = 2;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE, EN1, EN2, EN3, EX1, EX2, EX3, WAIT_CLR
   } state_t;

   // bit 1 = outer beam A, bit 0 = inner beam B, so deb lines up with {a,b}
   logic [NUM_SENS-1:0]            pins, sync1, sync2, deb;
   logic [NUM_SENS-1:0][CNT_W-1:0] cnt;

   state_t state, state_nx;
   logic   up_nx, down_nx;

   assign pins   = {sensor_a, sensor_b};
   assign deb_ab = deb;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= pins;
         sync2 <= sync1;
      end
   end

   // A sensor must disagree with its debounced value for DEBOUNCE_CYCLES
   // consecutive samples before the debounced value follows it.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
         deb <= '0;
      end else begin
         for (int i = 0; i < NUM_SENS; i++) begin
            if (sync2[i] == deb[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               deb[i] <= sync2[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      up_nx    = 1'b0;
      down_nx  = 1'b0;
      case (state)
         IDLE: case (deb)
            2'b10:   state_nx = EN1;
            2'b01:   state_nx = EX1;
            2'b11:   state_nx = WAIT_CLR;
            default: state_nx = state;
         endcase
         EN1: case (deb)
            2'b11:   state_nx = EN2;
            2'b00:   state_nx = IDLE;
            2'b01:   state_nx = WAIT_CLR;
            default: state_nx = state;
         endcase
         EN2: case (deb)
            2'b01:   state_nx = EN3;
            2'b10:   state_nx = EN1;
            2'b00:   state_nx = WAIT_CLR;
            default: state_nx = state;
         endcase
         EN3: case (deb)
            2'b00: begin
               state_nx = IDLE;
               up_nx    = 1'b1;
            end
            2'b11:   state_nx = EN2;
            2'b10:   state_nx = WAIT_CLR;
            default: state_nx = state;
         endcase
         EX1: case (deb)
            2'b11:   state_nx = EX2;
            2'b00:   state_nx = IDLE;
            2'b10:   state_nx = WAIT_CLR;
            default: state_nx = state;
         endcase
         EX2: case (deb)
            2'b10:   state_nx = EX3;
            2'b01:   state_nx = EX1;
            2'b00:   state_nx = WAIT_CLR;
            default: state_nx = state;
         endcase
         EX3: case (deb)
            2'b00: begin
               state_nx = IDLE;
               down_nx  = 1'b1;
            end
            2'b11:   state_nx = EX2;
            2'b01:   state_nx = WAIT_CLR;
            default: state_nx = state;
         endcase
         WAIT_CLR: begin
            if (deb == 2'b00) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         up     <= 1'b0;
         down   <= 1'b0;
         enable <= 1'b0;
      end else begin
         up     <= up_nx;
         down   <= down_nx;
         enable <= up_nx ^ down_nx;
      end
   end

`ifdef SEQ_ERR_EN
   // Strobe only on the entering edge, not while parked in WAIT_CLR.
   always_ff @(posedge clk) begin
      if (reset) seq_err <= 1'b0;
      else       seq_err <= (state_nx == WAIT_CLR) && (state != WAIT_CLR);
   end
`endif

endmodule
